alu_seq: RTL and testbench
==========================

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameters SHALL be:
- DATA_LEN, 16, operand/result width (>=4)
- OP_LEN, 4, opcode width
REQ-002 Ports SHALL be (clock and reset first):
- clk  in  1  clock; all state on rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  operation request
- in_ready  out  1  block can accept a request
- op  in  OP_LEN  opcode
- a  in  DATA_LEN  operand A
- b  in  DATA_LEN  operand B
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- result  out  DATA_LEN  operation result
- z_flag  out  1  result == 0
- c_flag  out  1  carry/borrow/overflow
- err  out  1  illegal op or divide-by-zero
REQ-003 Reset SHALL be reset, synchronous, active-high; clock SHALL be clk.

Function
REQ-004 Opcodes SHALL be: 0 ADD, 1 SUB, 2 MUL, 3 PASS_A, 4 PASS_B, 5 ZERO, 6 XOR, 7 AND, 8 OR, 9 DIV; all others illegal.
REQ-005 FSM states SHALL be IDLE, MUL, DIV, DONE.
REQ-006 in_ready SHALL be 1 only in IDLE; a request is accepted on a cycle with in_valid && in_ready, and op/a/b SHALL be captured into internal registers at acceptance.
REQ-007 Single-cycle ops (ADD, SUB, PASS_A, PASS_B, ZERO, XOR, AND, OR, illegal) SHALL go IDLE->DONE, with out_valid asserted in the cycle after acceptance (latency 1).
REQ-008 MUL SHALL be iterative shift-add: IDLE->MUL, exactly DATA_LEN cycles in MUL, then DONE (latency DATA_LEN+1); result = low DATA_LEN bits of a*b.
REQ-009 In DONE, out_valid=1 and result/flags SHALL hold stable until out_ready=1; on that cycle the FSM SHALL go to IDLE; no new request is accepted in the same cycle.
REQ-010 z_flag SHALL be 1 iff result==0, for every op.
REQ-011 c_flag: ADD carry-out; SUB borrow (a<b unsigned); MUL 1 iff upper DATA_LEN product bits are nonzero; 0 for all other ops.
REQ-012 Arithmetic SHALL be unsigned and modulo 2^DATA_LEN.
REQ-013 Illegal op SHALL give result=0, z_flag=1, c_flag=0, err=1; err SHALL be 0 for all legal ops except REQ-018.
REQ-014 Outside DONE, out_valid SHALL be 0; result and flags SHALL keep their last values.

Reset
REQ-015 On reset: state=IDLE, in_ready=1 from the first cycle after reset is deasserted, out_valid=0, result=0, z_flag=0, c_flag=0, err=0, internal operand/accumulator registers cleared.
REQ-016 Reset asserted mid-MUL/DIV or in DONE SHALL abort the operation and discard its result; no out_valid shall follow.

Configuration
REQ-017 Macro ALU_SEQ_DIV_EN SHALL compile in DIV: restoring division, DATA_LEN cycles in state DIV, latency DATA_LEN+1, result=a/b quotient, c_flag=1 iff remainder nonzero.
REQ-018 With ALU_SEQ_DIV_EN, b==0 SHALL give result all-ones, c_flag=0, err=1, latency 1.
REQ-019 Without ALU_SEQ_DIV_EN, opcode 9 SHALL be illegal (REQ-013) and no DIV state/logic SHALL exist.

Structure
REQ-020 Package alu_seq_pkg SHALL hold the opcode enum, FSM state enum, and OP_LEN default.
REQ-021 The iterative shift-add/subtract datapath SHALL be one sub-module, alu_seq_iter (start, mode mul/div, busy, done, 2*DATA_LEN result), instanced once.

Verification
REQ-022 ADD a=16'hFFFF, b=16'h0001 -> one cycle later out_valid=1, result=0, z_flag=1, c_flag=1, err=0.
REQ-023 MUL a=300, b=300 -> out_valid exactly 17 cycles after acceptance, result=16'h5F90, c_flag=1; in_ready=0 throughout.
REQ-024 SUB a=5, b=7 with out_ready=0 for 10 cycles -> result=16'hFFFE, c_flag=1 held stable with out_valid=1; in_ready=1 the cycle after out_ready pulses.
REQ-025 op=4'hF -> result=0, z_flag=1, err=1; with ALU_SEQ_DIV_EN, DIV a=100, b=7 -> result=14, c_flag=1; DIV b=0 -> result=16'hFFFF, err=1.
REQ-026 Reset asserted in cycle 5 of a MUL -> next cycle state IDLE, out_valid=0, all outputs 0, no stale result afterwards.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - opcode and FSM state types shared by the alu_seq slice
// ALU_SEQ_DIV_EN adds the DIV state.
package alu_seq_pkg;

   localparam int OP_LEN_DEF = 4;

   typedef enum logic [OP_LEN_DEF-1:0] {
      OP_ADD    = 4'd0,
      OP_SUB    = 4'd1,
      OP_MUL    = 4'd2,
      OP_PASS_A = 4'd3,
      OP_PASS_B = 4'd4,
      OP_ZERO   = 4'd5,
      OP_XOR    = 4'd6,
      OP_AND    = 4'd7,
      OP_OR     = 4'd8,
      OP_DIV    = 4'd9
   } op_t;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DONE = 2'd3
`ifdef ALU_SEQ_DIV_EN
      , S_DIV = 2'd2
`endif
   } state_t;

endpackage

// File: rtl/alu_seq_iter.sv
// rtl/alu_seq_iter.sv - iterative shift-add multiplier / restoring divider, one bit per cycle
// ALU_SEQ_DIV_EN adds the mode input and divide datapath; result is {hi, lo} of the final step.
module alu_seq_iter #(
   parameter int W = 16
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           start,
`ifdef ALU_SEQ_DIV_EN
   input  logic           mode,
`endif
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   output logic           busy,
   output logic           done,
   output logic [2*W-1:0] result
);

   localparam int CW = $clog2(W);
   localparam logic [CW-1:0] LAST = CW'(W - 1);

   logic           r_busy;
   logic [CW-1:0]  r_cnt;
   logic [2*W-1:0] r_acc;
   logic [2*W-1:0] r_mcand;
   logic [W-1:0]   r_mplier;
   logic [2*W-1:0] w_acc_mul;

   assign w_acc_mul = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

`ifdef ALU_SEQ_DIV_EN
   logic         r_mode;
   logic [W:0]   w_trial;
   logic [W:0]   w_sub;
   logic [W-1:0] w_rem;
   logic [W-1:0] w_quo;

   // Remainder lives in r_acc low half, divisor in r_mcand low half, dividend/quotient in r_mplier.
   assign w_trial = {r_acc[W-1:0], r_mplier[W-1]};
   assign w_sub   = w_trial - {1'b0, r_mcand[W-1:0]};
   assign w_rem   = w_sub[W] ? w_trial[W-1:0] : w_sub[W-1:0];
   assign w_quo   = {r_mplier[W-2:0], ~w_sub[W]};
   assign result  = r_mode ? {w_rem, w_quo} : w_acc_mul;
`else
   assign result  = w_acc_mul;
`endif

   assign busy = r_busy;
   assign done = r_busy && (r_cnt == LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_busy   <= 1'b0;
         r_cnt    <= '0;
         r_acc    <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
`ifdef ALU_SEQ_DIV_EN
         r_mode   <= 1'b0;
`endif
      end else if (start) begin
         r_busy   <= 1'b1;
         r_cnt    <= '0;
         r_acc    <= '0;
`ifdef ALU_SEQ_DIV_EN
         r_mode   <= mode;
         r_mcand  <= {{W{1'b0}}, mode ? b : a};
         r_mplier <= mode ? a : b;
`else
         r_mcand  <= {{W{1'b0}}, a};
         r_mplier <= b;
`endif
      end else if (r_busy) begin
         r_cnt <= r_cnt + 1'b1;
         if (r_cnt == LAST) r_busy <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
         if (r_mode) begin
            r_acc    <= {{W{1'b0}}, w_rem};
            r_mplier <= w_quo;
         end else
`endif
         begin
            r_acc    <= w_acc_mul;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
         end
      end
   end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - sequential ALU with valid/ready handshake and iterative MUL
// ALU_SEQ_DIV_EN compiles in the iterative DIV opcode.
module alu_seq
   import alu_seq_pkg::*;
#(
   parameter int DATA_LEN = 16,
   parameter int OP_LEN   = OP_LEN_DEF
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [OP_LEN-1:0]   op,
   input  logic [DATA_LEN-1:0] a,
   input  logic [DATA_LEN-1:0] b,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [DATA_LEN-1:0] result,
   output logic                z_flag,
   output logic                c_flag,
   output logic                err
);

   state_t                r_state;
   state_t                w_next;
   logic [DATA_LEN-1:0]   r_result;
   logic                  r_z;
   logic                  r_c;
   logic                  r_err;
   logic [DATA_LEN-1:0]   w_res;
   logic                  w_c;
   logic                  w_err;
   logic                  w_multi;
   logic                  w_accept;
   logic                  w_busy;
   logic                  w_done;
   logic [2*DATA_LEN-1:0] w_iter_res;
`ifdef ALU_SEQ_DIV_EN
   logic                  w_mode;
`endif

   assign in_ready  = (r_state == S_IDLE);
   assign out_valid = (r_state == S_DONE);
   assign w_accept  = in_valid && in_ready;
   assign result    = r_result;
   assign z_flag    = r_z;
   assign c_flag    = r_c;
   assign err       = r_err;

   // Single-cycle results are computed straight from the request so DONE follows acceptance.
   always_comb begin
      w_res   = '0;
      w_c     = 1'b0;
      w_err   = 1'b0;
      w_multi = 1'b0;
`ifdef ALU_SEQ_DIV_EN
      w_mode  = 1'b0;
`endif
      case (op)
         OP_ADD:    {w_c, w_res} = {1'b0, a} + {1'b0, b};
         OP_SUB:    {w_c, w_res} = {1'b0, a} - {1'b0, b};
         OP_MUL:    w_multi = 1'b1;
         OP_PASS_A: w_res = a;
         OP_PASS_B: w_res = b;
         OP_ZERO:   w_res = '0;
         OP_XOR:    w_res = a ^ b;
         OP_AND:    w_res = a & b;
         OP_OR:     w_res = a | b;
`ifdef ALU_SEQ_DIV_EN
         OP_DIV: begin
            if (b == '0) begin
               w_res = '1;
               w_err = 1'b1;
            end else begin
               w_multi = 1'b1;
               w_mode  = 1'b1;
            end
         end
`endif
         default:   w_err = 1'b1;
      endcase
   end

   alu_seq_iter #(.W(DATA_LEN)) u_iter (
      .clk    (clk),
      .reset  (reset),
      .start  (w_accept && w_multi),
`ifdef ALU_SEQ_DIV_EN
      .mode   (w_mode),
`endif
      .a      (a),
      .b      (b),
      .busy   (w_busy),
      .done   (w_done),
      .result (w_iter_res)
   );

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
`ifdef ALU_SEQ_DIV_EN
               if (w_multi) w_next = w_mode ? S_DIV : S_MUL;
`else
               if (w_multi) w_next = S_MUL;
`endif
               else         w_next = S_DONE;
            end
         end
`ifdef ALU_SEQ_DIV_EN
         S_DIV,
`endif
         S_MUL: begin
            if (w_done)       w_next = S_DONE;
            else if (!w_busy) w_next = S_IDLE;
         end
         S_DONE:  if (out_ready) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Upper half is product overflow for MUL and remainder for DIV; both map to c_flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_result <= '0;
         r_z      <= 1'b0;
         r_c      <= 1'b0;
         r_err    <= 1'b0;
      end else if (w_accept && !w_multi) begin
         r_result <= w_res;
         r_z      <= (w_res == '0);
         r_c      <= w_c;
         r_err    <= w_err;
      end else if ((r_state != S_IDLE) && (r_state != S_DONE) && w_done) begin
         r_result <= w_iter_res[DATA_LEN-1:0];
         r_z      <= (w_iter_res[DATA_LEN-1:0] == '0);
         r_c      <= |w_iter_res[2*DATA_LEN-1:DATA_LEN];
         r_err    <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - directed self-checking bench for alu_seq
// DIV vectors run only when ALU_SEQ_DIV_EN is defined.
module tb_alu_seq;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [3:0]  op = '0;
   logic [15:0] a = '0;
   logic [15:0] b = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [15:0] result;
   logic        z_flag;
   logic        c_flag;
   logic        err;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   alu_seq #(.DATA_LEN(16), .OP_LEN(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .z_flag    (z_flag),
      .c_flag    (c_flag),
      .err       (err)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_op(input string tag, input logic [3:0] i_op, input logic [15:0] i_a,
                         input logic [15:0] i_b, input int exp_lat, input logic [15:0] exp_res,
                         input logic exp_z, input logic exp_c, input logic exp_err,
                         input int hold);
      int   lat;
      logic rdy_low;
      logic stable;
      in_valid = 1'b1;
      op = i_op;
      a  = i_a;
      b  = i_b;
      tick();
      in_valid = 1'b0;
      op = 4'h0;
      a  = 16'h0;
      b  = 16'h0;
      lat = 1;
      rdy_low = 1'b1;
      while (!out_valid && lat < 100) begin
         if (in_ready) rdy_low = 1'b0;
         tick();
         lat++;
      end
      check({tag, " latency"}, lat, exp_lat);
      check({tag, " busy_ready"}, {31'b0, rdy_low}, 1);
      check({tag, " result"}, {16'b0, result}, {16'b0, exp_res});
      check({tag, " flags"}, {29'b0, z_flag, c_flag, err}, {29'b0, exp_z, exp_c, exp_err});
      stable = 1'b1;
      for (int i = 0; i < hold; i++) begin
         tick();
         if (!out_valid || result !== exp_res || c_flag !== exp_c || z_flag !== exp_z
             || err !== exp_err || in_ready) stable = 1'b0;
      end
      check({tag, " hold"}, {31'b0, stable}, 1);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check({tag, " idle_hs"}, {30'b0, in_ready, out_valid}, {30'b0, 2'b10});
      check({tag, " kept"}, {16'b0, result}, {16'b0, exp_res});
   endtask

   initial begin
      int   cyc;
      logic stale;
      tick();
      tick();
      reset = 1'b0;
      check("reset ready_valid", {30'b0, in_ready, out_valid}, {30'b0, 2'b10});
      check("reset outputs", {13'b0, result, z_flag, c_flag, err}, 32'h0);

      //       tag        op     a         b         lat res       z     c     err   hold
      run_op("add_wrap",  4'h0, 16'hFFFF, 16'h0001, 1,  16'h0000, 1'b1, 1'b1, 1'b0, 0);
      run_op("add",       4'h0, 16'h1234, 16'h1111, 1,  16'h2345, 1'b0, 1'b0, 1'b0, 0);
      run_op("sub_borrow",4'h1, 16'd5,    16'd7,    1,  16'hFFFE, 1'b0, 1'b1, 1'b0, 10);
      run_op("sub",       4'h1, 16'd7,    16'd5,    1,  16'h0002, 1'b0, 1'b0, 1'b0, 0);
      run_op("mul_ovf",   4'h2, 16'd300,  16'd300,  17, 16'h5F90, 1'b0, 1'b1, 1'b0, 0);
      run_op("mul",       4'h2, 16'd3,    16'd5,    17, 16'h000F, 1'b0, 1'b0, 1'b0, 2);
      run_op("mul_zero",  4'h2, 16'h0000, 16'h1234, 17, 16'h0000, 1'b1, 1'b0, 1'b0, 0);
      run_op("mul_max",   4'h2, 16'hFFFF, 16'hFFFF, 17, 16'h0001, 1'b0, 1'b1, 1'b0, 0);
      run_op("pass_a",    4'h3, 16'hBEEF, 16'h1234, 1,  16'hBEEF, 1'b0, 1'b0, 1'b0, 0);
      run_op("pass_b",    4'h4, 16'hBEEF, 16'h1234, 1,  16'h1234, 1'b0, 1'b0, 1'b0, 0);
      run_op("zero",      4'h5, 16'hBEEF, 16'h1234, 1,  16'h0000, 1'b1, 1'b0, 1'b0, 0);
      run_op("xor",       4'h6, 16'hA5A5, 16'hFFFF, 1,  16'h5A5A, 1'b0, 1'b0, 1'b0, 0);
      run_op("and",       4'h7, 16'hF0F0, 16'h3C3C, 1,  16'h3030, 1'b0, 1'b0, 1'b0, 0);
      run_op("or",        4'h8, 16'hF0F0, 16'h0F0F, 1,  16'hFFFF, 1'b0, 1'b0, 1'b0, 0);
      run_op("illegal_f", 4'hF, 16'h1234, 16'h5678, 1,  16'h0000, 1'b1, 1'b0, 1'b1, 0);
`ifdef ALU_SEQ_DIV_EN
      run_op("div_rem",   4'h9, 16'd100,  16'd7,    17, 16'd14,   1'b0, 1'b1, 1'b0, 0);
      run_op("div_exact", 4'h9, 16'd21,   16'd7,    17, 16'd3,    1'b0, 1'b0, 1'b0, 0);
      run_op("div_max",   4'h9, 16'hFFFF, 16'd1,    17, 16'hFFFF, 1'b0, 1'b0, 1'b0, 0);
      run_op("div_by0",   4'h9, 16'd100,  16'd0,    1,  16'hFFFF, 1'b0, 1'b0, 1'b1, 0);
`else
      run_op("op9_illeg", 4'h9, 16'd100,  16'd7,    1,  16'h0000, 1'b1, 1'b0, 1'b1, 0);
`endif
      run_op("pre_abort", 4'h6, 16'h00FF, 16'h0F00, 1,  16'h0FFF, 1'b0, 1'b0, 1'b0, 0);

      in_valid = 1'b1;
      op = 4'h2;
      a  = 16'd300;
      b  = 16'd300;
      tick();
      in_valid = 1'b0;
      repeat (4) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("abort ready_valid", {30'b0, in_ready, out_valid}, {30'b0, 2'b10});
      check("abort outputs", {13'b0, result, z_flag, c_flag, err}, 32'h0);
      stale = 1'b0;
      cyc = 0;
      while (cyc < 25) begin
         tick();
         if (out_valid || !in_ready) stale = 1'b1;
         cyc++;
      end
      check("abort no_stale", {31'b0, stale}, 0);

      run_op("post_abort",4'h0, 16'd2,    16'd3,    1,  16'd5,    1'b0, 1'b0, 1'b0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
